// File: rtl/unidade_busca_pkg.sv
// Shared definitions for the fetch/decode sequencer: opcodes, field positions and FSM states.
package unidade_busca_pkg;

   // Register-form opcodes
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOT  = 4'd5;
   // Immediate-form opcodes
   localparam logic [3:0] OP_ADDI = 4'd6;
   localparam logic [3:0] OP_SUBI = 4'd7;
   localparam logic [3:0] OP_ANDI = 4'd8;
   localparam logic [3:0] OP_ORI  = 4'd9;
   localparam logic [3:0] OP_LDI  = 4'd10;

   localparam logic [3:0] OP_IMM_FIRST = OP_ADDI;
   localparam logic [3:0] OP_IMM_LAST  = OP_LDI;
   localparam logic [3:0] OP_LAST      = OP_LDI;

   // Instruction field bit positions: [15:12] op, [11:8] rc, [7:4] ra/imm4, [3:0] rb
   localparam int unsigned OP_MSB = 15;
   localparam int unsigned OP_LSB = 12;
   localparam int unsigned RC_MSB = 11;
   localparam int unsigned RC_LSB = 8;
   localparam int unsigned RA_MSB = 7;
   localparam int unsigned RA_LSB = 4;
   localparam int unsigned RB_MSB = 3;
   localparam int unsigned RB_LSB = 0;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StWb     = 3'd4
   } estado_t;

   function automatic logic is_imm(input logic [3:0] op);
      return (op >= OP_IMM_FIRST) && (op <= OP_IMM_LAST);
   endfunction

   function automatic logic is_illegal(input logic [3:0] op);
      return op > OP_LAST;
   endfunction

endpackage

// File: rtl/unidade_busca_debounce_tecla.sv
// Key debouncer: 2-FF synchronizer, then a one-cycle pulse after DEB_CYCLES consecutive
// low samples; re-arms only after DEB_CYCLES consecutive high samples.
module debounce_tecla #(
   parameter int unsigned DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic pulse
);

   localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          key_meta;
   logic          key_sync;
   logic          armed;
   logic [CW-1:0] cnt;

   // Synchronizer; reset to the released (high) level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_meta <= 1'b1;
         key_sync <= 1'b1;
      end else begin
         key_meta <= key_n;
         key_sync <= key_meta;
      end
   end

   // Stability counter: counts low samples while armed, high samples while disarmed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed <= 1'b1;
         cnt   <= '0;
         pulse <= 1'b0;
      end else begin
         pulse <= 1'b0;
         if (armed) begin
            if (key_sync) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               cnt   <= '0;
               armed <= 1'b0;
               pulse <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            if (!key_sync) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               cnt   <= '0;
               armed <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch/decode sequencer: 16-word program memory loaded from switches,
// stepped one instruction per debounced key press through FETCH/DECODE/EXEC/WB.
module unidade_busca
   import unidade_busca_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 500000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        step_n,
   input  logic        load_n,
   input  logic        mode,
   input  logic [15:0] instr_in,
   output logic [3:0]  codeop,
   output logic [4:0]  endRegA,
   output logic [4:0]  endRegB,
   output logic [4:0]  endRegC,
   output logic [15:0] imm,
   output logic        flagimm,
   output logic        bancoRW,
   output logic [3:0]  pc,
   output logic        illegal,
   output logic        busy
);

   logic        step_pulse;
   logic        load_pulse;
   logic        mode_meta;
   logic        mode_sync;
   estado_t     state;
   estado_t     state_next;
   logic [15:0] ir;
   logic [15:0] imem [16];

   debounce_tecla #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb_step (
      .clk   (clk),
      .rst   (rst),
      .key_n (step_n),
      .pulse (step_pulse)
   );

   debounce_tecla #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb_load (
      .clk   (clk),
      .rst   (rst),
      .key_n (load_n),
      .pulse (load_pulse)
   );

   // Mode switch synchronizer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_meta <= 1'b0;
         mode_sync <= 1'b0;
      end else begin
         mode_meta <= mode;
         mode_sync <= mode_meta;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= StIdle;
      end else begin
         state <= state_next;
      end
   end

   // Next state and strobes; strobes depend only on registered state, so reset kills them at once
   always_comb begin
      state_next = state;
      busy       = (state != StIdle);
      bancoRW    = 1'b0;
      illegal    = 1'b0;
      unique case (state)
         StIdle:   if (step_pulse && mode_sync) state_next = StFetch;
         StFetch:  state_next = StDecode;
         StDecode: state_next = StExec;
         StExec:   state_next = StWb;
         StWb: begin
            state_next = StIdle;
            bancoRW    = !is_illegal(codeop);
            illegal    = is_illegal(codeop);
         end
         default:  state_next = StIdle;
      endcase
   end

   // Program memory and pc: loads only from IDLE in load mode, pc advances at end of WB
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            imem[i] <= '0;
         end
         pc <= '0;
      end else if ((state == StIdle) && !mode_sync && load_pulse) begin
         imem[pc] <= instr_in;
         pc       <= pc + 4'd1;
      end else if (state == StWb) begin
         pc <= pc + 4'd1;
      end
   end

   // Instruction register captured in FETCH
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir <= '0;
      end else if (state == StFetch) begin
         ir <= imem[pc];
      end
   end

   // Decoded fields registered in DECODE and held until the next DECODE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         codeop  <= '0;
         endRegA <= '0;
         endRegB <= '0;
         endRegC <= '0;
         imm     <= '0;
         flagimm <= 1'b0;
      end else if (state == StDecode) begin
         codeop  <= ir[OP_MSB:OP_LSB];
         endRegC <= {1'b0, ir[RC_MSB:RC_LSB]};
         endRegB <= {1'b0, ir[RB_MSB:RB_LSB]};
         if (is_imm(ir[OP_MSB:OP_LSB])) begin
            // ra field carries imm4; read port A keeps its previous address
            imm     <= {12'd0, ir[RA_MSB:RA_LSB]};
            flagimm <= 1'b1;
         end else begin
            endRegA <= {1'b0, ir[RA_MSB:RA_LSB]};
            imm     <= '0;
            flagimm <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_unidade_busca.sv
// Scoreboard bench for unidade_busca: stimulus pushes predicted write-back results,
// a monitor pops and compares whenever bancoRW or illegal is presented.
module tb_unidade_busca;

   localparam int unsigned D = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        step_n, load_n, mode;
   logic [15:0] instr_in;
   logic [3:0]  codeop, pc;
   logic [4:0]  endRegA, endRegB, endRegC;
   logic [15:0] imm;
   logic        flagimm, bancoRW, illegal, busy;

   // Second instance with a 1-cycle debouncer so a step can land mid-instruction
   logic        f_step_n, f_load_n, f_mode;
   logic [15:0] f_instr_in;
   logic [3:0]  f_codeop, f_pc;
   logic [4:0]  f_endRegA, f_endRegB, f_endRegC;
   logic [15:0] f_imm;
   logic        f_flagimm, f_bancoRW, f_illegal, f_busy;

   always #5 clk = ~clk;

   unidade_busca #(.DEB_CYCLES(D)) dut (
      .clk(clk), .rst(rst), .step_n(step_n), .load_n(load_n), .mode(mode),
      .instr_in(instr_in), .codeop(codeop), .endRegA(endRegA), .endRegB(endRegB),
      .endRegC(endRegC), .imm(imm), .flagimm(flagimm), .bancoRW(bancoRW), .pc(pc),
      .illegal(illegal), .busy(busy)
   );

   unidade_busca #(.DEB_CYCLES(1)) dut_fast (
      .clk(clk), .rst(rst), .step_n(f_step_n), .load_n(f_load_n), .mode(f_mode),
      .instr_in(f_instr_in), .codeop(f_codeop), .endRegA(f_endRegA), .endRegB(f_endRegB),
      .endRegC(f_endRegC), .imm(f_imm), .flagimm(f_flagimm), .bancoRW(f_bancoRW), .pc(f_pc),
      .illegal(f_illegal), .busy(f_busy)
   );

   typedef struct {
      logic [3:0]  op;
      logic [4:0]  a, b, c;
      logic [15:0] imm;
      logic        fimm;
      logic        ill;
      logic [3:0]  pc;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model state
   logic [15:0] m_mem [16];
   int          m_pc;
   int          m_rega;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
      m_pc   = 0;
      m_rega = 0;
   endtask

   // Expected result of executing the instruction at the model pc
   task automatic model_step();
      exp_t e;
      int   w, op;
      w      = int'(m_mem[m_pc]);
      op     = w / 4096;
      e.op   = 4'(op);
      e.c    = 5'((w / 256) % 16);
      e.b    = 5'(w % 16);
      e.ill  = (op > 10);
      e.pc   = 4'(m_pc);
      if (op >= 6 && op <= 10) begin
         e.imm  = 16'((w / 16) % 16);
         e.fimm = 1'b1;
         e.a    = 5'(m_rega);
      end else begin
         e.imm  = 16'h0000;
         e.fimm = 1'b0;
         m_rega = (w / 16) % 16;
         e.a    = 5'(m_rega);
      end
      m_pc = (m_pc + 1) % 16;
      q.push_back(e);
   endtask

   // Hold a key low for 'hold' cycles, then release long enough to re-arm and finish
   task automatic press(input bit is_step, input int hold);
      if (hold >= int'(D)) begin
         if (is_step && mode) model_step();
         if (!is_step && !mode) begin
            m_mem[m_pc] = instr_in;
            m_pc        = (m_pc + 1) % 16;
         end
      end
      @(negedge clk);
      if (is_step) step_n = 1'b0;
      else load_n = 1'b0;
      repeat (hold) @(negedge clk);
      step_n = 1'b1;
      load_n = 1'b1;
      repeat (D + 8) @(negedge clk);
   endtask

   // Monitor: compares every write-back against the scoreboard, then the cycle after it
   initial begin : monitor
      exp_t cur;
      bit   pend;
      int   busy_run;
      pend     = 0;
      busy_run = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend     = 0;
            busy_run = 0;
         end else begin
            if (pend) begin
               chk("pc_after_wb", 32'(pc), 32'((int'(cur.pc) + 1) % 16));
               chk("busy_after_wb", 32'(busy), 32'd0);
               chk("strobe_after_wb", 32'({bancoRW, illegal}), 32'd0);
               chk("held_codeop", 32'(codeop), 32'(cur.op));
               chk("held_regA", 32'(endRegA), 32'(cur.a));
               pend = 0;
            end
            busy_run = busy ? busy_run + 1 : 0;
            if (bancoRW || illegal) begin
               if (q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_wb: bancoRW=%0b illegal=%0b with nothing expected",
                           bancoRW, illegal);
               end else begin
                  cur = q.pop_front();
                  chk("wb_codeop", 32'(codeop), 32'(cur.op));
                  chk("wb_regA", 32'(endRegA), 32'(cur.a));
                  chk("wb_regB", 32'(endRegB), 32'(cur.b));
                  chk("wb_regC", 32'(endRegC), 32'(cur.c));
                  chk("wb_imm", 32'(imm), 32'(cur.imm));
                  chk("wb_flagimm", 32'(flagimm), 32'(cur.fimm));
                  chk("wb_bancoRW", 32'(bancoRW), 32'(!cur.ill));
                  chk("wb_illegal", 32'(illegal), 32'(cur.ill));
                  chk("wb_pc", 32'(pc), 32'(cur.pc));
                  chk("wb_busy_cycle", 32'(busy_run), 32'd4);
                  pend = 1;
               end
            end
         end
      end
   end

   int f_bw_cnt = 0;
   initial begin : fast_counter
      forever begin
         @(negedge clk);
         if (!rst && f_bancoRW) f_bw_cnt++;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stimulus
      logic [15:0] prog [16];
      int          k;
      rst = 1'b1; step_n = 1'b1; load_n = 1'b1; mode = 1'b0; instr_in = 16'h0000;
      f_step_n = 1'b1; f_load_n = 1'b1; f_mode = 1'b1; f_instr_in = 16'h0000;
      model_reset();
      repeat (3) @(negedge clk);

      chk("rst_codeop", 32'(codeop), 32'd0);
      chk("rst_regs", 32'({endRegA, endRegB, endRegC}), 32'd0);
      chk("rst_imm", 32'(imm), 32'd0);
      chk("rst_flags", 32'({flagimm, bancoRW, illegal, busy}), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Fast instance: second step pulse two cycles after the first is dropped
      @(negedge clk) f_step_n = 1'b0;
      @(negedge clk) f_step_n = 1'b1;
      @(negedge clk) f_step_n = 1'b0;
      @(negedge clk) f_step_n = 1'b1;
      repeat (15) @(negedge clk);
      chk("drop_step_wb_count", 32'(f_bw_cnt), 32'd1);
      chk("drop_step_pc", 32'(f_pc), 32'd1);
      @(negedge clk) f_step_n = 1'b0;
      @(negedge clk) f_step_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("later_step_wb_count", 32'(f_bw_cnt), 32'd2);
      chk("later_step_pc", 32'(f_pc), 32'd2);

      // Load program; 16 loads wrap pc back to 0
      prog[0] = 16'h1234;
      prog[1] = 16'h6A53;
      prog[2] = 16'hF123;
      for (int i = 3; i < 16; i++) prog[i] = 16'($urandom);
      for (int i = 0; i < 16; i++) begin
         instr_in = prog[i];
         press(1'b0, int'($urandom_range(D, 3 * D)));
      end
      chk("pc_wrap_load", 32'(pc), 32'd0);
      press(1'b1, 3 * D);
      chk("step_ignored_load_mode", 32'(pc), 32'd0);

      mode = 1'b1;
      repeat (4) @(negedge clk);
      instr_in = 16'hFFFF;
      press(1'b0, 3 * D);
      chk("load_ignored_exec_mode", 32'(pc), 32'd0);

      // First three instructions against literal decodes
      press(1'b1, 3 * D);
      chk("i0_fields", 32'({codeop, endRegC, endRegA, endRegB, flagimm}),
          32'({4'd1, 5'd2, 5'd3, 5'd4, 1'b0}));
      press(1'b1, 3 * D);
      chk("i1_fields", 32'({codeop, endRegC, endRegB, flagimm}), 32'({4'd6, 5'd10, 5'd3, 1'b1}));
      chk("i1_imm", 32'(imm), 32'h0005);
      chk("i1_regA_kept", 32'(endRegA), 32'd3);
      press(1'b1, 3 * D);
      chk("illegal_pc_inc", 32'(pc), 32'd3);

      // Debounce boundary: one sample short of a press
      press(1'b1, int'(D) - 1);
      chk("glitch_no_exec", 32'(pc), 32'd3);

      // Random run, long enough to wrap pc 15 -> 0; holds straddle the debounce threshold
      for (int i = 0; i < 22; i++) press(1'b1, int'($urandom_range(D - 1, 3 * D)));
      chk("pc_after_run", 32'(pc), 32'(m_pc));

      // Reset during WB
      @(negedge clk) step_n = 1'b0;
      model_step();
      k = 0;
      while (!(bancoRW || illegal) && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk("wb_reached", 32'(k < 60), 32'd1);
      step_n = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("rst_wb_strobes", 32'({bancoRW, illegal, busy}), 32'd0);
      chk("rst_wb_pc", 32'(pc), 32'd0);
      chk("rst_wb_fields", 32'({codeop, endRegA, endRegB, endRegC, flagimm}), 32'd0);
      chk("rst_wb_imm", 32'(imm), 32'd0);
      q.delete();
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // imem was cleared: the next instruction is 0x0000
      press(1'b1, 3 * D);
      chk("post_rst_pc", 32'(pc), 32'd1);

      repeat (10) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/unidade_busca.md
# unidade_busca

Instruction fetch/decode sequencer sitting directly upstream of the processor datapath (control unit, register bank, ALU). It holds a 16-word program loaded from the switches, steps through it one instruction per debounced key press, and drives the datapath with decoded register addresses, immediate, opcode and a single-cycle register-bank write strobe. It replaces ad-hoc key-level decoding with a cycle-exact FSM.

## Interface
- DEB_CYCLES, 500000: consecutive stable cycles required by the key debouncer (10 ms at 50 MHz).
- clk  in  1  system clock (CLOCK_50).
- rst  in  1  reset; asynchronous, active-high.
- step_n  in  1  execute key, active-low, asynchronous to clk.
- load_n  in  1  load key, active-low, asynchronous to clk.
- mode  in  1  0 = load program, 1 = execute; synchronized internally.
- instr_in  in  16  instruction word from switches.
- codeop  out  4  opcode to control unit/ALU.
- endRegA, endRegB, endRegC  out  5 each  register-bank read A, read B, write addresses (bit 4 always 0).
- imm  out  16  zero-extended immediate.
- flagimm  out  1  immediate-form instruction.
- bancoRW  out  1  register-bank write strobe, one cycle.
- pc  out  4  program counter.
- illegal  out  1  one-cycle pulse: opcode 11..15 retired.
- busy  out  1  FSM not in IDLE.

## Operation
- Instruction format: [15:12] opcode, [11:8] rc, [7:4] ra or imm4, [3:0] rb.
- Opcodes 0..5: endRegC=rc, endRegA=ra, endRegB=rb, imm=0, flagimm=0.
- Opcodes 6..10: endRegC=rc, imm={12'd0, imm4}, endRegB=rb, endRegA unchanged, flagimm=1.
- Opcodes 11..15: illegal; fields decoded as register form, no write.
- Two debouncer instances (step, load): 2-FF synchronizer, counter; emits one-cycle pulse after DEB_CYCLES consecutive low samples; re-arms only after DEB_CYCLES consecutive high samples.
- Load (mode=0): load pulse writes instr_in to imem[pc], pc <= pc+1. Step pulses ignored.
- Execute (mode=1): step pulse in IDLE starts FSM; load pulses ignored.
- FSM: IDLE -> FETCH (IR <= imem[pc]) -> DECODE (register output fields from IR) -> EXEC (one cycle for registered ALU result) -> WB (bancoRW=1 if legal, else illegal=1; pc <= pc+1) -> IDLE.
- Step pulse while busy: dropped, not queued.
- mode change mid-instruction: current instruction completes; new mode applies from IDLE.
- pc wraps 15 -> 0 in both modes.
- Reset: state IDLE, pc=0, IR=0, imem cleared to 0, all outputs 0, debouncers re-armed; takes effect immediately even mid-instruction (bancoRW dropped same instant).

## Timing
- Step pulse high in cycle T (IDLE): FETCH T+1, DECODE T+2, fields valid from T+3, EXEC T+3, WB T+4 (bancoRW/illegal high exactly in T+4), pc incremented and IDLE at T+5.
- busy high T+1..T+4.
- Decoded fields are registered and held constant from DECODE until the next DECODE.
- Load pulse in cycle T: imem and pc updated at T+1 edge.
- Key press to pulse: DEB_CYCLES + 2 cycles (synchronizer).
- No output is combinational from any input.

## Structure
- Shared package: opcode constants (OP_ADD..OP_last, OP_IMM_FIRST=6, OP_IMM_LAST=10), FSM state encoding (3-bit), instruction field bit positions.
- Sub-module: debounce_tecla (parameter DEB_CYCLES; ports clk, rst, key_n, pulse), instantiated twice.
- imem: 16x16 flop array, not inferred RAM (needs reset clear).

## Test plan
- Reset mid-WB: assert rst during WB -> bancoRW 0 immediately, pc=0, busy=0, all outputs 0.
- Load and run (DEB_CYCLES=4): mode=0, load 0x1234 and 0x6A53, mode=1, step -> codeop=1, endRegC=2, endRegA=3, endRegB=4, flagimm=0, bancoRW pulse at T+4; step -> codeop=6, endRegC=10, imm=0x0005, endRegB=3, flagimm=1.
- Illegal opcode: execute 0xF123 -> illegal pulse at T+4, bancoRW stays 0, pc increments.
- Step while busy: second step pulse at T+2 -> ignored, exactly one bancoRW pulse, pc +1 only.
- Wrap: 16 loads -> pc returns to 0; 16 steps from pc=15 region -> pc 15 -> 0.
- Debounce: step_n glitch low for DEB_CYCLES-1 cycles -> no pulse; hold low 3*DEB_CYCLES -> exactly one instruction executed.
